// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: one DIGIT-bit adder slice, operands shifted LSB digit first,
// carry registered between digits. Results are published only when the last digit completes.
module serial_add_sub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic [1:0]       o_dbg_state
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("serial_add_sub: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic [DIGIT:0]   w_slice;
    logic             w_msb_cin;
    logic [WIDTH-1:0] w_acc_next;

    // Handshake: start is honoured whenever no operation is in flight (IDLE or DONE);
    // busy stays high for exactly N cycles and done pulses once when results change.
    assign w_accept = start && (r_state != S_RUN);
    assign w_last   = (r_state == S_RUN) && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_cnt == LAST) w_state_next = S_DONE;
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = start ? S_RUN : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_slice = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};

    // The carry into the top bit of a digit is recovered from that bit's sum: s = a ^ b ^ c.
    assign w_msb_cin = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_slice[DIGIT-1];

    generate
        if (N == 1) begin : g_one_digit
            assign w_acc_next = w_slice[DIGIT-1:0];
        end else begin : g_multi_digit
            assign w_acc_next = {w_slice[DIGIT-1:0], r_acc[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is a + ~b + ~cin, so the borrow-in inverts along with b.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? ~cin : cin;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_carry <= w_slice[DIGIT];
            r_acc   <= w_acc_next;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_sum  <= w_acc_next;
                r_cout <= w_slice[DIGIT];
                r_ovf  <= w_msb_cin ^ w_slice[DIGIT];
            end
        end
    end

    assign sum         = r_sum;
    assign cout        = r_cout;
    assign overflow    = r_ovf;
    assign o_dbg_state = r_state;

endmodule
